mem_req_master: RTL and testbench



---
 rtl/mem_pkg.sv | 14 +
 rtl/cmd_fifo.sv | 51 +++++
 rtl/mem_req_master.sv | 138 +++++++++++++
 tb/tb_mem_req_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory request master and its command FIFO.
package mem_pkg;
    localparam int MEM_WIDTH      = 8;
    localparam int MEM_DEPTH      = 32;
    localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic                      wr_rd;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_WIDTH-1:0]      wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with wrap-around pointers; count carries one extra bit so
// full and empty are distinguishable.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cmd_fifo DEPTH must be a power of 2 and >= 2");
    end

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = store[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Payload storage needs no reset: it is only read when count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) store[wptr] <= wdata;
    end
endmodule

// File: rtl/mem_req_master.sv
// Queues commands and issues each to the memory exactly once as a one-cycle strobe.
// Optional WAIT timeout with rsp_err output: define MEM_REQ_MASTER_TIMEOUT_EN.
module mem_req_master
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wdata,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ready,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  done,
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    output logic                  rsp_err,
`endif
    output logic                  busy
);
    // cmd_t is sized by the package, so overrides must track it.
    if (WIDTH != MEM_WIDTH || ADDR_WIDTH != MEM_ADDR_WIDTH || TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_req_master parameters disagree with mem_pkg or TIMEOUT < 1");
    end

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    cmd_t          push_cmd, head;
    logic          full, empty, pop;
    logic [CW-1:0] count;

    assign push_cmd  = {cmd_wr_rd, cmd_addr, cmd_wdata};
    assign cmd_ready = !full;
    assign busy      = (state != IDLE) || (count != '0);

    // Pop on a fresh start from IDLE, or chained straight off a completion.
    assign pop = !empty && ((state == IDLE) || (state == WAIT && mem_ready));

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata (push_cmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_wr_rd <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
            done      <= 1'b0;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            mem_valid <= 1'b0;
            rsp_valid <= 1'b0;
            done      <= 1'b0;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            if (pop) begin
                mem_valid <= 1'b1;
                mem_wr_rd <= head.wr_rd;
                mem_addr  <= head.addr;
                mem_wdata <= head.wdata;
            end
            case (state)
                IDLE: if (pop) state <= ISSUE;
                ISSUE: begin
                    state <= WAIT;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (mem_ready) begin
                        done <= 1'b1;
                        if (!mem_wr_rd) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= mem_rdata;
                            rsp_addr  <= mem_addr;
                        end
                        state <= pop ? ISSUE : IDLE;
                    end
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT)) begin
                        done    <= 1'b1;
                        rsp_err <= 1'b1;
                        if (!mem_wr_rd) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_addr  <= mem_addr;
                        end
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a behavioural single-port memory.
`timescale 1ns/1ps
module tb_mem_req_master;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_wr_rd = 1'b0;
    logic [4:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       mem_valid, mem_wr_rd, mem_ready;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       rsp_valid, done, busy;
    logic [7:0] rsp_rdata;
    logic [4:0] rsp_addr;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    logic       rsp_err;
`endif

    int checks = 0, failures = 0;

    mem_req_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
        .done(done),
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: samples the strobe, answers with a one-cycle ready. mem_hold
    // delays the answer; mem_off models the memory held in its own reset.
    logic [7:0] marr [32];
    logic       pend, mem_hold = 1'b0, mem_off = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst || mem_off) begin
            pend      <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            if (mem_valid) begin
                if (mem_wr_rd) marr[mem_addr] <= mem_wdata;
                else           mem_rdata      <= marr[mem_addr];
            end
            if ((mem_valid || pend) && !mem_hold) begin
                mem_ready <= 1'b1;
                pend      <= 1'b0;
            end else if (mem_valid) begin
                pend <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [4:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    logic       c_wr   [16];
    logic [4:0] c_addr [16];
    logic [7:0] c_data [16];
    int         done_cyc[$];
    logic [4:0] iss[$], ra_q[$];
    logic [7:0] rd_q[$];
    int         full_push;

    // Streams n queued commands with cmd_valid held, logging the outcome.
    task automatic run_cmds(input int n, input int rel_cyc, input int budget);
        int   idx = 0;
        int   c = 0;
        logic pushed;
        done_cyc.delete(); iss.delete(); rd_q.delete(); ra_q.delete();
        full_push = -1;
        while (done_cyc.size() < n && c < budget) begin
            if (c == rel_cyc) mem_hold = 1'b0;
            if (idx < n) drive(c_wr[idx], c_addr[idx], c_data[idx]);
            else         cmd_valid = 1'b0;
            if (!cmd_ready && full_push < 0) full_push = idx;
            pushed = cmd_valid && cmd_ready;
            tick();
            c++;
            if (pushed) idx++;
            if (mem_valid) iss.push_back(mem_addr);
            if (done) done_cyc.push_back(c);
            if (rsp_valid) begin
                rd_q.push_back(rsp_rdata);
                ra_q.push_back(rsp_addr);
            end
        end
        cmd_valid = 1'b0;
        chk("run_done_count", done_cyc.size(), n);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) marr[i] = 8'h00;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr",  mem_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_done",      done, 0);
        chk("rst_busy",      busy, 0);
        rst = 1'b0;
        tick();

        // Single write: strobe exactly one cycle, address stable in WAIT
        drive(1'b1, 5'd2, 8'h3C);
        tick(); cmd_valid = 1'b0;
        chk("w1_e0_busy", busy, 1);
        chk("w1_e0_mem_valid", mem_valid, 0);
        tick();
        chk("w1_e1_mem_valid", mem_valid, 1);
        chk("w1_e1_mem_addr",  mem_addr, 2);
        chk("w1_e1_mem_wr_rd", mem_wr_rd, 1);
        chk("w1_e1_mem_wdata", mem_wdata, 8'h3C);
        tick();
        chk("w1_e2_mem_valid", mem_valid, 0);
        chk("w1_e2_mem_addr",  mem_addr, 2);
        tick();
        chk("w1_e3_done",      done, 1);
        chk("w1_e3_rsp_valid", rsp_valid, 0);
        tick();
        chk("w1_e4_done", done, 0);
        chk("w1_e4_busy", busy, 0);

        // Write then read back the same address
        drive(1'b1, 5'd5, 8'hA5);
        tick();
        drive(1'b0, 5'd5, 8'h00);
        tick(); cmd_valid = 1'b0;
        chk("wr_e1_mem_valid", mem_valid, 1);
        chk("wr_e1_mem_wr_rd", mem_wr_rd, 1);
        tick();
        tick();
        chk("wr_e3_done",      done, 1);
        chk("wr_e3_rsp_valid", rsp_valid, 0);
        chk("wr_e3_issue_rd",  {mem_valid, mem_wr_rd}, 2'b10);
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
        chk("wr_e3_rsp_err", rsp_err, 0);
`endif
        tick();
        chk("wr_e4_done", done, 0);
        tick();
        chk("rd_e5_rsp_valid", rsp_valid, 1);
        chk("rd_e5_rsp_rdata", rsp_rdata, 8'hA5);
        chk("rd_e5_rsp_addr",  rsp_addr, 5);
        chk("rd_e5_done",      done, 1);
        tick();
        chk("rd_e6_rsp_valid", rsp_valid, 0);
        chk("rd_e6_rdata_held", rsp_rdata, 8'hA5);
        chk("rd_e6_busy", busy, 0);

        // Fill the FIFO behind a stalled access, then drain in order
        for (int i = 0; i < 6; i++) begin
            c_wr[i] = 1'b1; c_addr[i] = 5'(i); c_data[i] = 8'h10 + 8'(i);
        end
        mem_hold = 1'b1;
        run_cmds(6, 8, 200);
        chk("full_at_push", full_push, 5);
        for (int i = 0; i < 6; i++) chk("full_issue_order", iss[i], i);
        for (int i = 1; i < 6; i++) chk("full_done_spacing", done_cyc[i] - done_cyc[i-1], 2);
        tick();

        // Read back addresses 0..5
        for (int i = 0; i < 6; i++) begin
            c_wr[i] = 1'b0; c_addr[i] = 5'(i); c_data[i] = 8'h00;
        end
        run_cmds(6, -1, 200);
        for (int i = 0; i < 6; i++) begin
            chk("rb_rdata", rd_q[i], 8'h10 + i);
            chk("rb_addr",  ra_q[i], i);
        end
        tick();

        // Alternating write/read stream wraps the FIFO pointers
        for (int j = 0; j < 5; j++) begin
            c_wr[2*j]   = 1'b1; c_addr[2*j]   = 5'(16 + j); c_data[2*j]   = 8'hA0 + 8'(j);
            c_wr[2*j+1] = 1'b0; c_addr[2*j+1] = 5'(16 + j); c_data[2*j+1] = 8'h00;
        end
        run_cmds(10, -1, 200);
        chk("wrap_rsp_count", rd_q.size(), 5);
        for (int j = 0; j < 5; j++) begin
            chk("wrap_rdata", rd_q[j], 8'hA0 + j);
            chk("wrap_addr",  ra_q[j], 16 + j);
        end
        tick();

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
        // Memory held in reset: read of addr 3 aborts after the WAIT timeout
        mem_off = 1'b1;
        drive(1'b0, 5'd3, 8'h00);
        tick(); cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", n, 18);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_rsp_addr", rsp_addr, 3);
        chk("to_done", done, 1);
        tick();
        chk("to_err_pulse", rsp_err, 0);
        mem_off = 1'b0;
        tick();
`endif

        // Asynchronous reset while a read is stuck in WAIT
        mem_hold = 1'b1;
        drive(1'b0, 5'd7, 8'h00);
        tick(); cmd_valid = 1'b0;
        tick(); tick();
        chk("mr_pre_addr", mem_addr, 7);
        chk("mr_pre_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("mr_mem_valid", mem_valid, 0);
        chk("mr_mem_addr",  mem_addr, 0);
        chk("mr_rsp_rdata", rsp_rdata, 0);
        chk("mr_rsp_addr",  rsp_addr, 0);
        chk("mr_done",      done, 0);
        chk("mr_busy",      busy, 0);
        chk("mr_cmd_ready", cmd_ready, 1);
        mem_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid || done) n++;
        end
        chk("mr_no_rsp_after", n, 0);
        chk("mr_busy_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
